axi_lite_int_ctrl: RTL and testbench

AXI4-Lite slave countdown timer that raises a level interrupt when the count expires. It is the peripheral that the block-design AXI master (VIP in simulation, PS GP port in hardware) writes into, and it drives the design's `INTERRUPT` net. Software programs a reload value, enables counting, and acknowledges interrupts by writing 1 to clear a status bit.

---
 rtl/axi_lite_int_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_axi_lite_int_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_int_ctrl.sv
// AXI4-Lite countdown timer: CTRL/LOAD/COUNT/STATUS registers, level interrupt on expiry.
// Independent AW/W holding registers; one outstanding write response and one outstanding read.
module axi_lite_int_ctrl #(
   parameter int C_ADDR_WIDTH = 4,
   parameter int C_DATA_WIDTH = 32
) (
   input  logic                      ACLK,
   input  logic                      ARESETN,
   input  logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic                      S_AXI_AWVALID,
   output logic                      S_AXI_AWREADY,
   input  logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                      S_AXI_WVALID,
   output logic                      S_AXI_WREADY,
   output logic [1:0]                S_AXI_BRESP,
   output logic                      S_AXI_BVALID,
   input  logic                      S_AXI_BREADY,
   input  logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic                      S_AXI_ARVALID,
   output logic                      S_AXI_ARREADY,
   output logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                S_AXI_RRESP,
   output logic                      S_AXI_RVALID,
   input  logic                      S_AXI_RREADY,
   output logic                      INTERRUPT
);

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_LOAD   = 2'd1,
      REG_COUNT  = 2'd2,
      REG_STATUS = 2'd3
   } reg_sel_e;

   // write holding registers
   logic                      aw_held_q, aw_held_d;
   reg_sel_e                  aw_sel_q, aw_sel_d;
   logic                      w_held_q, w_held_d;
   logic [C_DATA_WIDTH-1:0]   w_data_q, w_data_d;
   logic [C_DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
   logic                      bvalid_q, bvalid_d;

   // read channel
   logic                      rvalid_q, rvalid_d;
   logic [C_DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [C_DATA_WIDTH-1:0]   rd_mux;
   logic                      ar_hs;

   // timer state
   logic                      en_q, en_d;
   logic                      irq_en_q, irq_en_d;
   logic                      reload_q, reload_d;
   logic [C_DATA_WIDTH-1:0]   load_q, load_d;
   logic [C_DATA_WIDTH-1:0]   count_q, count_d;
   logic                      pending_q, pending_d;
   logic                      irq_q, irq_d;

   logic                      commit;
   logic                      wr_ctrl, wr_load, wr_status;
   logic                      ctrl_wr_en, status_clr, expire;
   logic                      unused_addr_bits;

   assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

   assign S_AXI_AWREADY = ~aw_held_q;
   assign S_AXI_WREADY  = ~w_held_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = ~rvalid_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign INTERRUPT     = irq_q;

   assign commit    = aw_held_q & w_held_q & ~bvalid_q;
   assign wr_ctrl   = commit & (aw_sel_q == REG_CTRL);
   assign wr_load   = commit & (aw_sel_q == REG_LOAD);
   assign wr_status = commit & (aw_sel_q == REG_STATUS);
   assign ar_hs     = S_AXI_ARVALID & ~rvalid_q;

   always_comb begin
      aw_held_d = aw_held_q;
      aw_sel_d  = aw_sel_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      if (commit) begin
         aw_held_d = 1'b0;
      end else if (S_AXI_AWVALID && !aw_held_q) begin
         aw_held_d = 1'b1;
         aw_sel_d  = reg_sel_e'(S_AXI_AWADDR[3:2]);
      end
      if (commit) begin
         w_held_d = 1'b0;
      end else if (S_AXI_WVALID && !w_held_q) begin
         w_held_d = 1'b1;
         w_data_d = S_AXI_WDATA;
         w_strb_d = S_AXI_WSTRB;
      end
      if (commit) begin
         bvalid_d = 1'b1;
      end else if (S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (reg_sel_e'(S_AXI_ARADDR[3:2]))
         REG_CTRL:   rd_mux[2:0] = {reload_q, irq_en_q, en_q};
         REG_LOAD:   rd_mux      = load_q;
         REG_COUNT:  rd_mux      = count_q;
         REG_STATUS: rd_mux[0]   = pending_q;
         default:    rd_mux      = '0;
      endcase
   end

   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_mux;
      end else if (S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   assign ctrl_wr_en = wr_ctrl & w_strb_q[0];
   assign status_clr = wr_status & w_strb_q[0] & w_data_q[0];
   // expiry is the cycle COUNT sits at 0 with EN set; covers LOAD=0 as well
   assign expire     = en_q & (count_q == '0);

   always_comb begin
      load_d = load_q;
      if (wr_load) begin
         for (int unsigned b = 0; b < C_DATA_WIDTH / 8; b++) begin
            if (w_strb_q[b]) load_d[8*b +: 8] = w_data_q[8*b +: 8];
         end
      end
   end

   always_comb begin
      count_d  = count_q;
      en_d     = en_q;
      irq_en_d = irq_en_q;
      reload_d = reload_q;
      if (en_q) begin
         if (count_q != '0) begin
            count_d = count_q - {{(C_DATA_WIDTH-1){1'b0}}, 1'b1};
         end else if (reload_q) begin
            count_d = load_q;
         end else begin
            en_d = 1'b0;
         end
      end
      // a software CTRL write overrides the hardware EN clear
      if (ctrl_wr_en) begin
         en_d     = w_data_q[0];
         irq_en_d = w_data_q[1];
         reload_d = w_data_q[2];
         if (w_data_q[0] && !en_q) count_d = load_q;
      end
   end

   always_comb begin
      pending_d = pending_q;
      if (expire) begin
         pending_d = 1'b1;
      end else if (status_clr) begin
         pending_d = 1'b0;
      end
      irq_d = pending_q & irq_en_q;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_held_q <= 1'b0;
         aw_sel_q  <= REG_CTRL;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         en_q      <= 1'b0;
         irq_en_q  <= 1'b0;
         reload_q  <= 1'b0;
         load_q    <= '0;
         count_q   <= '0;
         pending_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         aw_held_q <= aw_held_d;
         aw_sel_q  <= aw_sel_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         en_q      <= en_d;
         irq_en_q  <= irq_en_d;
         reload_q  <= reload_d;
         load_q    <= load_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         irq_q     <= irq_d;
      end
   end

endmodule

// File: tb/tb_axi_lite_int_ctrl.sv
// Directed bench for axi_lite_int_ctrl: register access, AXI ordering/backpressure, timer and interrupt timing.
module tb_axi_lite_int_ctrl;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [3:0]  S_AXI_AWADDR = '0;
   logic        S_AXI_AWVALID = 1'b0;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA = '0;
   logic [3:0]  S_AXI_WSTRB = '0;
   logic        S_AXI_WVALID = 1'b0;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY = 1'b1;
   logic [3:0]  S_AXI_ARADDR = '0;
   logic        S_AXI_ARVALID = 1'b0;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY = 1'b1;
   logic        INTERRUPT;

   axi_lite_int_ctrl #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .INTERRUPT     (INTERRUPT)
   );

   always #5 ACLK = ~ACLK;

   // cyc equals k after the k-th rising edge; INTERRUPT logged per cycle at the falling edge
   int unsigned cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;
   logic irq_log [0:4095];
   always @(negedge ACLK) if (cyc < 4096) irq_log[cyc] = INTERRUPT;

   int n_checks = 0;
   int n_fail   = 0;
   int unsigned last_commit = 0;
   int unsigned last_rd = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic wait_until(input int unsigned target);
      int unsigned n;
      n = 0;
      while (cyc < target && n < 500) begin
         tick();
         n++;
      end
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      bit aw_done, w_done, aw_hs, w_hs;
      int unsigned n;
      aw_done = 1'b0;
      w_done  = 1'b0;
      n = 0;
      S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
      while (!(aw_done && w_done) && n < 20) begin
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         tick();
         if (aw_hs) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
         if (w_hs)  begin w_done = 1'b1; S_AXI_WVALID = 1'b0; end
         n++;
      end
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      n = 0;
      while (!S_AXI_BVALID && n < 20) begin
         tick();
         n++;
      end
      check_eq("write_bvalid", S_AXI_BVALID, 1);
      check_eq("write_bresp", S_AXI_BRESP, 0);
      last_commit = cyc;
      tick();
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
      bit done, hs;
      int unsigned n;
      done = 1'b0;
      n = 0;
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
      while (!done && n < 20) begin
         hs = S_AXI_ARVALID && S_AXI_ARREADY;
         tick();
         if (hs) done = 1'b1;
         n++;
      end
      S_AXI_ARVALID = 1'b0;
      last_rd = cyc;
      check_eq("read_rvalid_latency", S_AXI_RVALID, 1);
      check_eq("read_rresp", S_AXI_RRESP, 0);
      d = S_AXI_RDATA;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int unsigned c, d, bcount, stay_hi, w1c_a, w1c_b;

      repeat (3) @(posedge ACLK);
      #1 ARESETN = 1'b1;

      // reset state
      check_eq("rst_awready", S_AXI_AWREADY, 1);
      check_eq("rst_wready", S_AXI_WREADY, 1);
      check_eq("rst_arready", S_AXI_ARREADY, 1);
      check_eq("rst_bvalid", S_AXI_BVALID, 0);
      check_eq("rst_rvalid", S_AXI_RVALID, 0);
      check_eq("rst_rdata", S_AXI_RDATA, 0);
      check_eq("rst_interrupt", INTERRUPT, 0);
      axi_read(4'h0, rd); check_eq("rst_ctrl", rd, 32'h0);
      axi_read(4'h4, rd); check_eq("rst_load", rd, 32'h0);
      axi_read(4'h8, rd); check_eq("rst_count", rd, 32'h0);
      axi_read(4'hC, rd); check_eq("rst_status", rd, 32'h0);

      // reset mid-read
      axi_write(4'h0, 32'h2, 4'hF);
      axi_read(4'h0, rd); check_eq("ctrl_irqen", rd, 32'h2);
      S_AXI_RREADY = 1'b0;
      S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1;
      tick();
      S_AXI_ARVALID = 1'b0;
      check_eq("rvalid_before_reset", S_AXI_RVALID, 1);
      check_eq("rdata_before_reset", S_AXI_RDATA, 32'h2);
      #2 ARESETN = 1'b0;
      #1;
      check_eq("rvalid_async_reset", S_AXI_RVALID, 0);
      check_eq("rdata_async_reset", S_AXI_RDATA, 0);
      check_eq("arready_async_reset", S_AXI_ARREADY, 1);
      @(posedge ACLK); @(posedge ACLK);
      #1 ARESETN = 1'b1;
      S_AXI_RREADY = 1'b1;
      axi_read(4'h0, rd); check_eq("ctrl_after_reset", rd, 32'h0);

      // byte strobes, aliasing, reserved bits, read-only COUNT
      axi_write(4'h4, 32'hDEADBEEF, 4'hF);
      axi_write(4'h4, 32'h00001100, 4'h2);
      axi_read(4'h4, rd); check_eq("load_strobe", rd, 32'hDEAD11EF);
      axi_read(4'h5, rd); check_eq("load_alias", rd, 32'hDEAD11EF);
      axi_write(4'h0, 32'hFFFFFFF8, 4'hF);
      axi_read(4'h0, rd); check_eq("ctrl_reserved", rd, 32'h0);
      axi_write(4'h0, 32'h00000007, 4'hE);
      axi_read(4'h0, rd); check_eq("ctrl_strobe_off", rd, 32'h0);
      axi_write(4'h8, 32'h00001234, 4'hF);
      axi_read(4'h8, rd); check_eq("count_ro", rd, 32'h0);

      // W presented 3 cycles ahead of AW
      S_AXI_WDATA = 32'h000000A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      bcount = 0;
      tick();
      S_AXI_WVALID = 1'b0;
      check_eq("wready_held", S_AXI_WREADY, 0);
      for (int i = 0; i < 2; i++) begin
         if (S_AXI_BVALID) bcount++;
         tick();
      end
      S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (S_AXI_BVALID) begin
            bcount++;
            check_eq("w_first_bresp", S_AXI_BRESP, 0);
         end
         tick();
      end
      check_eq("w_first_bcount", bcount, 1);
      axi_read(4'h4, rd); check_eq("w_first_data", rd, 32'h000000A5);

      // one-shot: LOAD=5, EN|IRQ_EN
      axi_write(4'h4, 32'd5, 4'hF);
      axi_write(4'h0, 32'h3, 4'hF);
      c = last_commit;
      wait_until(c + 9);
      check_eq("oneshot_irq_early", irq_log[c + 6], 0);
      check_eq("oneshot_irq_rise", irq_log[c + 7], 1);
      axi_read(4'h0, rd); check_eq("oneshot_ctrl", rd, 32'h2);
      axi_read(4'h8, rd); check_eq("oneshot_count", rd, 32'h0);
      axi_read(4'hC, rd); check_eq("oneshot_pending", rd, 32'h1);
      axi_write(4'hC, 32'h1, 4'hE);
      axi_read(4'hC, rd); check_eq("status_strobe_off", rd, 32'h1);
      axi_write(4'hC, 32'h0, 4'hF);
      axi_read(4'hC, rd); check_eq("status_write0", rd, 32'h1);
      axi_write(4'hC, 32'h1, 4'h1);
      d = last_commit;
      wait_until(d + 2);
      check_eq("irq_before_clear", irq_log[d], 1);
      check_eq("irq_fall", irq_log[d + 1], 0);
      axi_read(4'hC, rd); check_eq("status_cleared", rd, 32'h0);

      // running COUNT read returns the pre-decrement value; EN=0 freezes
      axi_write(4'h4, 32'd100, 4'hF);
      axi_write(4'h0, 32'h1, 4'hF);
      c = last_commit;
      axi_read(4'h8, rd); check_eq("count_running", rd, 100 - (last_rd - 1 - c));
      axi_write(4'h0, 32'h0, 4'hF);
      d = last_commit;
      axi_read(4'h8, rd); check_eq("count_frozen", rd, 100 - (d - c));
      repeat (5) tick();
      axi_read(4'h8, rd); check_eq("count_frozen_later", rd, 100 - (d - c));

      // auto-reload LOAD=3: expiries at c+4, c+8, c+12
      axi_write(4'h4, 32'd3, 4'hF);
      axi_write(4'h0, 32'h7, 4'hF);
      c = last_commit;
      wait_until(c + 6);
      axi_write(4'hC, 32'h1, 4'h1);
      w1c_a = last_commit;
      axi_write(4'hC, 32'h1, 4'h1);
      w1c_b = last_commit;
      wait_until(c + 15);
      check_eq("reload_w1c_a_cycle", w1c_a - c, 8);
      check_eq("reload_w1c_b_cycle", w1c_b - c, 11);
      check_eq("reload_irq_c4", irq_log[c + 4], 0);
      check_eq("reload_irq_c5", irq_log[c + 5], 1);
      check_eq("reload_set_wins_c9", irq_log[c + 9], 1);
      check_eq("reload_set_wins_c10", irq_log[c + 10], 1);
      check_eq("reload_cleared_c12", irq_log[c + 12], 0);
      check_eq("reload_reset_c13", irq_log[c + 13], 1);
      axi_write(4'h0, 32'h0, 4'hF);
      axi_write(4'hC, 32'h1, 4'h1);

      // write-response backpressure
      S_AXI_BREADY = 1'b0;
      S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h11; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      tick();
      check_eq("bp_first_bvalid", S_AXI_BVALID, 1);
      S_AXI_WDATA = 32'h22; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      check_eq("bp_awready_drop", S_AXI_AWREADY, 0);
      check_eq("bp_wready_drop", S_AXI_WREADY, 0);
      stay_hi = 0;
      for (int i = 0; i < 10; i++) begin
         if (S_AXI_BVALID) stay_hi++;
         tick();
      end
      check_eq("bp_bvalid_held", stay_hi, 10);
      axi_read(4'h4, rd); check_eq("bp_load_not_committed", rd, 32'h11);
      check_eq("bp_bvalid_still", S_AXI_BVALID, 1);
      S_AXI_BREADY = 1'b1;
      bcount = 0;
      for (int i = 0; i < 8; i++) begin
         if (S_AXI_BVALID) bcount++;
         tick();
      end
      check_eq("bp_response_count", bcount, 2);
      axi_read(4'h4, rd); check_eq("bp_second_data", rd, 32'h22);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
